// File: rtl/intra_pkg.sv
// intra_pkg: bank geometry, FSM state encoding and the TU-size to group-count helper
package intra_pkg;
    localparam int NBANK = 8;
    localparam int PIX_PER_BANK = 4;
    localparam int LEFT_BASE_DEF = 128;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ROW = 2'd1;
    localparam logic [1:0] S_COL = 2'd2;
    // Out-of-range sizes fall back to the largest TU (8 groups of 4 pixels)
    function automatic logic [3:0] grp_cnt(input logic [2:0] log2sz);
        return (log2sz >= 3'd2 && log2sz <= 3'd5) ? 4'd1 << (log2sz - 3'd2) : 4'd8;
    endfunction
endpackage

// File: rtl/intra_bank_scatter.sv
// intra_bank_scatter: rotates up to 8 consecutive 4-pixel groups onto the banks selected by their group index
module intra_bank_scatter
    import intra_pkg::*;
#(
    parameter int BD = 8,
    parameter int AW = 8
) (
    input  logic [6:0]                        base_i,
    input  logic [3:0]                        n_i,
    input  logic [6:0]                        limit_i,
    input  logic [AW-1:0]                     off_i,
    input  logic [BD*PIX_PER_BANK*NBANK-1:0]  line_i,
    output logic [BD*PIX_PER_BANK*NBANK-1:0]  word_o,
    output logic [AW*NBANK-1:0]               adr_o,
    output logic [NBANK-1:0]                  en_o
);
    localparam int WW = BD * PIX_PER_BANK;
    // Bank b receives the unique group k whose index base+k lands on b
    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        logic [2:0] k;
        logic [6:0] g;
        assign k = 3'(b) - base_i[2:0];
        assign g = base_i + {4'd0, k};
        assign en_o[b] = ({1'b0, k} < n_i) && (g < limit_i);
        assign adr_o[AW*(NBANK-1-b) +: AW] = off_i + AW'(g[6:3]);
        assign word_o[WW*(NBANK-1-b) +: WW] = line_i[WW*k +: WW];
    end
endmodule

// File: rtl/intra_nbr_writer.sv
// intra_nbr_writer: turns one TU boundary job into a ROW beat (plus TL corner) and a COL beat for the neighbour SRAM
module intra_nbr_writer
    import intra_pkg::*;
#(
    parameter int bitDepth  = 8,
    parameter int SRAMDW    = bitDepth * 4,
    parameter int AW        = 8,
    parameter int AW_TL     = 11,
    parameter int LEFT_BASE = LEFT_BASE_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       job_valid,
    output logic                       job_ready,
    input  logic [5:0]                 job_x4,
    input  logic [4:0]                 job_y4,
    input  logic [2:0]                 job_log2sz,
    input  logic [bitDepth*32-1:0]     job_row,
    input  logic [bitDepth*32-1:0]     job_col,
    input  logic [bitDepth-1:0]        job_tl,
    input  logic [6:0]                 pic_w4,
    input  logic [5:0]                 pic_h4,
    input  logic                       wr_stall,
    output logic [AW*NBANK-1:0]        wAdr,
    output logic [SRAMDW*NBANK-1:0]    wData,
    output logic [AW_TL-1:0]           wAdr_TL,
    output logic [bitDepth-1:0]        wData_TL,
    output logic [8:0]                 wE_n,
    output logic                       busy
);
    logic [1:0] state_q, state_d;
    logic [4:0] y4_q, y4_d;
    logic [3:0] n_q, n_d;
    logic [bitDepth*32-1:0] col_q, col_d;
    logic [AW*NBANK-1:0] wadr_q, wadr_d;
    logic [SRAMDW*NBANK-1:0] wdata_q, wdata_d;
    logic [AW_TL-1:0] wadr_tl_q, wadr_tl_d;
    logic [bitDepth-1:0] wdata_tl_q, wdata_tl_d;
    logic [8:0] we_q, we_d;
    logic [3:0] n_in;
    logic [4:0] tl_y;
    logic [5:0] tl_x;
    logic accept, to_col, to_idle;
    logic [NBANK-1:0] row_en, col_en, s_en;
    logic [AW*NBANK-1:0] row_adr, col_adr, s_adr;
    logic [SRAMDW*NBANK-1:0] row_word, col_word, s_word;

    assign n_in = grp_cnt(job_log2sz);
    assign tl_y = job_y4 + 5'(n_in) - 5'd1;
    assign tl_x = job_x4 + 6'(n_in) - 6'd1;
    assign job_ready = (state_q == S_IDLE) | ((state_q == S_COL) & ~wr_stall);
    assign accept = job_valid & job_ready;
    assign to_col = (state_q == S_ROW) & ~wr_stall;
    assign to_idle = (state_q == S_COL) & ~wr_stall & ~accept;
    assign busy = state_q != S_IDLE;
    assign wE_n = we_q | {9{wr_stall}};
    assign wAdr = wadr_q;
    assign wData = wdata_q;
    assign wAdr_TL = wadr_tl_q;
    assign wData_TL = wdata_tl_q;

    // ROW beat is built straight from the incoming job so it can be registered on the accept edge
    intra_bank_scatter #(.BD(bitDepth), .AW(AW)) u_row (
        .base_i  ({1'b0, job_x4}),
        .n_i     (n_in),
        .limit_i (pic_w4),
        .off_i   ('0),
        .line_i  (job_row),
        .word_o  (row_word),
        .adr_o   (row_adr),
        .en_o    (row_en)
    );

    intra_bank_scatter #(.BD(bitDepth), .AW(AW)) u_col (
        .base_i  ({2'b0, y4_q}),
        .n_i     (n_q),
        .limit_i ({1'b0, pic_h4}),
        .off_i   (AW'(LEFT_BASE)),
        .line_i  (col_q),
        .word_o  (col_word),
        .adr_o   (col_adr),
        .en_o    (col_en)
    );

    always_comb begin
        s_en = accept ? row_en : to_col ? col_en : '0;
        s_adr = accept ? row_adr : col_adr;
        s_word = accept ? row_word : col_word;
        state_d = accept ? S_ROW : to_col ? S_COL : to_idle ? S_IDLE : state_q;
        y4_d = accept ? job_y4 : y4_q;
        n_d = accept ? n_in : n_q;
        col_d = accept ? job_col : col_q;
        we_d = accept ? {1'b0, ~row_en} : to_col ? {1'b1, ~col_en} : to_idle ? 9'h1FF : we_q;
        wadr_tl_d = accept ? AW_TL'({tl_y, tl_x}) : wadr_tl_q;
        wdata_tl_d = accept ? job_tl : wdata_tl_q;
        wadr_d = wadr_q;
        wdata_d = wdata_q;
        // Disabled banks hold their last address/data to avoid toggling the SRAM inputs
        for (int b = 0; b < NBANK; b++) begin
            if (s_en[b]) begin
                wadr_d[AW*(NBANK-1-b) +: AW] = s_adr[AW*(NBANK-1-b) +: AW];
                wdata_d[SRAMDW*(NBANK-1-b) +: SRAMDW] = s_word[SRAMDW*(NBANK-1-b) +: SRAMDW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            y4_q <= '0;
            n_q <= '0;
            col_q <= '0;
            wadr_q <= '0;
            wdata_q <= '0;
            wadr_tl_q <= '0;
            wdata_tl_q <= '0;
            we_q <= 9'h1FF;
        end else begin
            state_q <= state_d;
            y4_q <= y4_d;
            n_q <= n_d;
            col_q <= col_d;
            wadr_q <= wadr_d;
            wdata_q <= wdata_d;
            wadr_tl_q <= wadr_tl_d;
            wdata_tl_q <= wdata_tl_d;
            we_q <= we_d;
        end
    end
endmodule

// File: tb/tb_intra_nbr_writer.sv
// tb_intra_nbr_writer: scoreboard bench; expected beats are queued on accept and compared as beats appear
module tb_intra_nbr_writer;
    typedef struct {
        logic [8:0]   we;
        logic [63:0]  adr;
        logic [255:0] dat;
        logic [10:0]  atl;
        logic [7:0]   dtl;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic job_valid = 1'b0;
    logic job_ready;
    logic [5:0] job_x4 = '0;
    logic [4:0] job_y4 = '0;
    logic [2:0] job_log2sz = 3'd2;
    logic [255:0] job_row = '0;
    logic [255:0] job_col = '0;
    logic [7:0] job_tl = '0;
    logic [6:0] pic_w4 = 7'd16;
    logic [5:0] pic_h4 = 6'd16;
    logic wr_stall = 1'b0;
    logic [63:0] wAdr;
    logic [255:0] wData;
    logic [10:0] wAdr_TL;
    logic [7:0] wData_TL;
    logic [8:0] wE_n;
    logic busy;

    int tests = 0;
    int fails = 0;
    int run = 0;
    int max_run = 0;
    bit rand_on = 1'b0;
    beat_t sb[$];
    beat_t e;

    intra_nbr_writer dut (
        .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
        .job_x4(job_x4), .job_y4(job_y4), .job_log2sz(job_log2sz),
        .job_row(job_row), .job_col(job_col), .job_tl(job_tl),
        .pic_w4(pic_w4), .pic_h4(pic_h4), .wr_stall(wr_stall),
        .wAdr(wAdr), .wData(wData), .wAdr_TL(wAdr_TL), .wData_TL(wData_TL),
        .wE_n(wE_n), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic beat_t mk(input bit row, input int base, input int lim, input int off,
                                 input int l2, input logic [255:0] line, input int x4, input int y4,
                                 input logic [7:0] tl);
        beat_t r;
        int n, g, bk;
        n = (l2 >= 2 && l2 <= 5) ? (1 << (l2 - 2)) : 8;
        r.we = '1; r.adr = '0; r.dat = '0; r.atl = '0; r.dtl = '0;
        for (int k = 0; k < n; k++) begin
            g = base + k;
            if (g < lim) begin
                bk = g % 8;
                r.we[bk] = 1'b0;
                r.adr[8*(7-bk) +: 8] = 8'(off + g / 8);
                r.dat[32*(7-bk) +: 32] = line[32*k +: 32];
            end
        end
        if (row) begin
            r.we[8] = 1'b0;
            r.atl = 11'((((y4 + n - 1) & 31) << 6) | ((x4 + n - 1) & 63));
            r.dtl = tl;
        end
        return r;
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // Monitor: pop/compare any beat on the bus, then queue the beats of a job accepted at the next edge
    initial forever begin
        @(negedge clk);
        if (!rst && wE_n !== 9'h1FF) begin
            run++;
            if (run > max_run) max_run = run;
            if (sb.size() == 0) chk("spurious_beat", wE_n, 9'h1FF);
            else begin
                e = sb.pop_front();
                chk("beat_we_n", wE_n, e.we);
                for (int b = 0; b < 8; b++) begin
                    if (!e.we[b]) begin
                        chk($sformatf("beat_adr_b%0d", b), wAdr[8*(7-b) +: 8], e.adr[8*(7-b) +: 8]);
                        chk($sformatf("beat_dat_b%0d", b), wData[32*(7-b) +: 32], e.dat[32*(7-b) +: 32]);
                    end
                end
                if (!e.we[8]) begin
                    chk("beat_adr_tl", wAdr_TL, e.atl);
                    chk("beat_dat_tl", wData_TL, e.dtl);
                end
            end
        end else run = 0;
        if (!rst && job_valid && job_ready) begin
            sb.push_back(mk(1'b1, int'(job_x4), int'(pic_w4), 0, int'(job_log2sz), job_row,
                            int'(job_x4), int'(job_y4), job_tl));
            sb.push_back(mk(1'b0, int'(job_y4), int'(pic_h4), 128, int'(job_log2sz), job_col,
                            int'(job_x4), int'(job_y4), job_tl));
        end
    end

    initial forever begin
        @(posedge clk);
        #3;
        if (rand_on) wr_stall = ($urandom_range(0, 3) == 0);
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Returns one time unit after the accepting edge; keep leaves valid high for a back-to-back job
    task automatic send(input int x4, input int y4, input int l2, input bit keep);
        bit ok;
        if (!job_valid) begin
            @(posedge clk);
            #1;
        end
        job_x4 = 6'(x4);
        job_y4 = 5'(y4);
        job_log2sz = 3'(l2);
        job_row = rnd256();
        job_col = rnd256();
        job_tl = 8'($urandom);
        job_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = job_ready;
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        if (!keep) job_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = !busy && sb.size() == 0;
        end
        if (!ok) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_we_n", wE_n, 9'h1FF);
        chk("rst_busy", busy, 0);
        chk("rst_ready", job_ready, 1);
        chk("rst_wadr", wAdr, 0);
        chk("rst_wdata", wData, 0);
        chk("rst_tl", {wAdr_TL, wData_TL}, 0);

        send(3, 0, 3, 1'b0);
        @(negedge clk);
        chk("a_row_we_n", wE_n, 9'h0E7);
        chk("a_b3_adr", wAdr[39:32], 0);
        chk("a_b3_dat", wData[159:128], job_row[31:0]);
        chk("a_row_busy", busy, 1);
        @(negedge clk);
        chk("a_col_we_n", wE_n, 9'h1FC);
        chk("a_b0_adr", wAdr[63:56], 128);
        wait_idle();

        send(6, 0, 5, 1'b0);
        @(negedge clk);
        chk("big_we_n", wE_n, 9'h000);
        chk("big_b6_adr", wAdr[15:8], 0);
        chk("big_b0_adr", wAdr[63:56], 1);
        chk("big_b0_dat", wData[255:224], job_row[95:64]);
        wait_idle();

        pic_w4 = 7'd8;
        send(6, 2, 4, 1'b0);
        @(negedge clk);
        chk("edge_we_n", wE_n[7:0], 8'h3F);
        wait_idle();
        pic_w4 = 7'd16;

        max_run = 0;
        send(1, 3, 3, 1'b1);
        send(9, 4, 2, 1'b1);
        send(12, 5, 4, 1'b0);
        wait_idle();
        chk("b2b_run", max_run, 6);

        send(2, 1, 3, 1'b0);
        wr_stall = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stall_we_n", wE_n, 9'h1FF);
            chk("stall_ready", job_ready, 0);
        end
        @(posedge clk);
        #1;
        wr_stall = 1'b0;
        @(negedge clk);
        chk("replay_we_n", wE_n, 9'h0F3);
        wait_idle();

        send(4, 6, 3, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("col_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_we_n", wE_n, 9'h1FF);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", job_ready, 1);
        repeat (4) @(negedge clk);
        chk("midrst_quiet", wE_n, 9'h1FF);

        rand_on = 1'b1;
        for (int j = 0; j < 12; j++)
            send($urandom_range(0, 20), $urandom_range(0, 15), $urandom_range(0, 7), j[0]);
        job_valid = 1'b0;
        rand_on = 1'b0;
        @(posedge clk);
        #5;
        wr_stall = 1'b0;
        wait_idle();
        chk("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
